bird_motion: RTL and testbench

//  Per-frame vertical physics for the bird sprite: gravity, flap impulse, floor/ceiling limits, game state.

---
 rtl/bird_motion.sv | 173 +++++++++++++++++
 tb/tb_bird_motion.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion.sv
// Bird vertical physics, advanced once per video frame.
// A synchronised frame_clk rising edge becomes a one-cycle tick; on each tick the
// bird applies gravity or a flap impulse, is limited by the floor and ceiling, and
// the IDLE/FLY/DEAD game state advances.
// Ports:
//   Clk, Reset      system clock, synchronous active-high reset
//   frame_clk       frame strobe, asynchronous to Clk
//   flap_key        flap button level (1 = pressed)
//   collide         pipe collision flag, honoured on a tick while flying
//   BallX/BallY     bird centre position
//   Ball_size       bird radius
//   alive/game_over FLY / DEAD state flags
//   state           00 IDLE, 01 FLY, 10 DEAD
module bird_motion #(
    parameter logic        [9:0] X_POS    = 10'd160,
    parameter logic        [9:0] Y_START  = 10'd240,
    parameter logic        [9:0] SIZE     = 10'd8,
    parameter logic        [9:0] Y_MIN    = 10'd0,
    parameter logic        [9:0] Y_MAX    = 10'd479,
    parameter logic signed [7:0] GRAVITY  = 8'sd1,
    parameter logic signed [7:0] FLAP_VEL = -8'sd6,
    parameter logic signed [7:0] MAX_FALL = 8'sd8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       flap_key,
    input  logic       collide,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic       alive,
    output logic       game_over,
    output logic [1:0] state
);

    localparam int unsigned POS_W = 12;
    localparam int unsigned VEL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FLY  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    // Screen limits widened to the signed position width
    localparam logic signed [POS_W-1:0] SIZE_S  = POS_W'(SIZE);
    localparam logic signed [POS_W-1:0] Y_MIN_S = POS_W'(Y_MIN);
    localparam logic signed [POS_W-1:0] Y_MAX_S = POS_W'(Y_MAX);
    localparam logic        [9:0]       Y_FLAP  = 10'(POS_W'(Y_START) + POS_W'(FLAP_VEL));
    localparam logic        [9:0]       Y_FLOOR = Y_MAX - SIZE;
    localparam logic        [9:0]       Y_CEIL  = Y_MIN + SIZE;

    state_t                    state_q, state_n;
    logic        [9:0]         y_q, y_nx;
    logic signed [VEL_W-1:0]   vel_q, vel_nx;
    logic                      pend_q, pend_nx;
    logic                      key_d;
    logic                      f1, f2, f3;
    logic                      alive_nx, game_over_nx;

    logic                      tick;
    logic                      flap_edge;
    logic                      flap;
    logic signed [VEL_W:0]     vel_sum;
    logic signed [VEL_W-1:0]   vel_clamp;
    logic signed [VEL_W-1:0]   vel_n;
    logic signed [POS_W-1:0]   y_n;

    assign BallX     = X_POS;
    assign Ball_size = SIZE;
    assign BallY     = y_q;
    assign state     = state_q;

    // Frame strobe synchroniser and rising-edge pulse
    assign tick      = f2 & ~f3;
    assign flap_edge = flap_key & ~key_d;
    // An edge arriving on the tick cycle is used immediately
    assign flap      = pend_q | flap_edge;

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            y_q       <= Y_START;
            vel_q     <= '0;
            pend_q    <= 1'b0;
            key_d     <= 1'b0;
            f1        <= 1'b0;
            f2        <= 1'b0;
            f3        <= 1'b0;
            alive     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_n;
            y_q       <= y_nx;
            vel_q     <= vel_nx;
            pend_q    <= pend_nx;
            key_d     <= flap_key;
            f1        <= frame_clk;
            f2        <= f1;
            f3        <= f2;
            alive     <= alive_nx;
            game_over <= game_over_nx;
        end
    end

    // Next-state, physics and flag decode
    always_comb begin
        state_n  = state_q;
        y_nx     = y_q;
        vel_nx   = vel_q;
        pend_nx  = pend_q;

        // Several presses inside one frame collapse into a single pending flap
        if (tick) begin
            pend_nx = 1'b0;
        end else if (flap_edge) begin
            pend_nx = 1'b1;
        end

        vel_sum   = (VEL_W+1)'(vel_q) + (VEL_W+1)'(GRAVITY);
        vel_clamp = (vel_sum > (VEL_W+1)'(MAX_FALL)) ? MAX_FALL : $signed(vel_sum[VEL_W-1:0]);
        vel_n     = flap ? FLAP_VEL : vel_clamp;
        y_n       = $signed({2'b00, y_q}) + POS_W'(vel_n);

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    y_nx   = Y_START;
                    vel_nx = '0;
                    if (flap) begin
                        state_n = ST_FLY;
                        y_nx    = Y_FLAP;
                        vel_nx  = FLAP_VEL;
                    end
                end
                ST_FLY: begin
                    if (collide) begin
                        state_n = ST_DEAD;
                        vel_nx  = '0;
                    end else if ((y_n + SIZE_S) >= Y_MAX_S) begin
                        state_n = ST_DEAD;
                        y_nx    = Y_FLOOR;
                        vel_nx  = '0;
                    end else if ((y_n - SIZE_S) < Y_MIN_S) begin
                        y_nx    = Y_CEIL;
                        vel_nx  = '0;
                    end else begin
                        y_nx    = y_n[9:0];
                        vel_nx  = vel_n;
                    end
                end
                ST_DEAD: begin
                    if (flap) begin
                        state_n = ST_IDLE;
                        y_nx    = Y_START;
                        vel_nx  = '0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    y_nx    = Y_START;
                    vel_nx  = '0;
                end
            endcase
        end

        alive_nx     = (state_n == ST_FLY);
        game_over_nx = (state_n == ST_DEAD);
    end

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: each frame pushes the expected position/state
// from a reference model into a queue, which is popped once the tick has landed.
module tb_bird_motion;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       flap_key;
    logic       collide;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] Ball_size;
    logic       alive;
    logic       game_over;
    logic [1:0] st_o;

    typedef struct packed {
        logic [1:0] st;
        logic [9:0] y;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_st;
    int m_y;
    int m_vel;

    bird_motion dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .flap_key  (flap_key),
        .collide   (collide),
        .BallX     (BallX),
        .BallY     (BallY),
        .Ball_size (Ball_size),
        .alive     (alive),
        .game_over (game_over),
        .state     (st_o)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: timeout observed 1 required 0");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_y   = 240;
        m_vel = 0;
    endtask

    task automatic model_step(input bit fl, input bit col);
        int vn;
        int yn;
        case (m_st)
            0: if (fl) begin
                m_st  = 1;
                m_vel = -6;
                m_y   = 234;
            end
            1: begin
                vn = fl ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
                yn = m_y + vn;
                if (col) begin
                    m_st  = 2;
                    m_vel = 0;
                end else if (yn + 8 >= 479) begin
                    m_st  = 2;
                    m_y   = 471;
                    m_vel = 0;
                end else if (yn - 8 < 0) begin
                    m_y   = 8;
                    m_vel = 0;
                end else begin
                    m_y   = yn;
                    m_vel = vn;
                end
            end
            default: if (fl) begin
                m_st  = 0;
                m_y   = 240;
                m_vel = 0;
            end
        endcase
    endtask

    task automatic pop_check(input string tag);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty observed 0 expected 1", tag);
        end else begin
            last_e = sb.pop_front();
            check({tag, ".state"}, 32'(st_o), 32'(last_e.st));
            check({tag, ".y"}, 32'(BallY), 32'(last_e.y));
            check({tag, ".alive"}, 32'(alive), 32'(last_e.st == 2'b01));
            check({tag, ".game_over"}, 32'(game_over), 32'(last_e.st == 2'b10));
        end
    endtask

    // One frame: n_press flap presses before the frame, optional press on the tick cycle
    task automatic do_frame(input int n_press, input bit fl_tick, input bit col, input string tag);
        @(negedge Clk);
        for (int i = 0; i < n_press; i++) begin
            flap_key = 1'b1;
            @(negedge Clk);
            flap_key = 1'b0;
            @(negedge Clk);
        end
        model_step((n_press > 0) || fl_tick, col);
        sb.push_back('{st: 2'(m_st), y: 10'(m_y)});
        collide   = col;
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        if (fl_tick) flap_key = 1'b1;
        @(negedge Clk);
        flap_key  = 1'b0;
        collide   = 1'b0;
        frame_clk = 1'b0;
        pop_check(tag);
        repeat (4) @(negedge Clk);
        check({tag, ".hold_y"}, 32'(BallY), 32'(last_e.y));
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        flap_key  = 1'b0;
        collide   = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        check("rst.state", 32'(st_o), 32'd0);
        check("rst.y", 32'(BallY), 32'd240);
        check("rst.x", 32'(BallX), 32'd160);
        check("rst.size", 32'(Ball_size), 32'd8);
        check("rst.alive", 32'(alive), 32'd0);
        check("rst.game_over", 32'(game_over), 32'd0);

        do_frame(0, 1'b0, 1'b0, "idle_noflap");

        // Launch and rise: 234, 229, 225, 222
        do_frame(1, 1'b0, 1'b0, "launch");
        check("launch.y_const", 32'(BallY), 32'd234);
        do_frame(0, 1'b0, 1'b0, "rise1");
        check("rise1.y_const", 32'(BallY), 32'd229);
        do_frame(0, 1'b0, 1'b0, "rise2");
        check("rise2.y_const", 32'(BallY), 32'd225);
        do_frame(0, 1'b0, 1'b0, "rise3");
        check("rise3.y_const", 32'(BallY), 32'd222);

        for (int i = 0; i < 8; i++) do_frame(0, 1'b0, 1'b0, "arc");
        check("arc.y_const", 32'(BallY), 32'd234);

        // Two presses within one frame act as a single flap
        do_frame(2, 1'b0, 1'b0, "double_flap");
        check("double_flap.y_const", 32'(BallY), 32'd228);

        for (int i = 0; i < 13; i++) do_frame(0, 1'b0, 1'b0, "glide");
        check("glide.y_const", 32'(BallY), 32'd241);

        // Terminal velocity clamp: +8 each frame from vel 7
        do_frame(0, 1'b0, 1'b0, "clamp1");
        check("clamp1.y_const", 32'(BallY), 32'd249);
        do_frame(0, 1'b0, 1'b0, "clamp2");
        check("clamp2.y_const", 32'(BallY), 32'd257);
        do_frame(0, 1'b0, 1'b0, "clamp3");
        check("clamp3.y_const", 32'(BallY), 32'd265);

        for (int i = 0; i < 40 && m_y != 465; i++) do_frame(0, 1'b0, 1'b0, "fall");
        check("fall.y_const", 32'(BallY), 32'd465);

        // Floor hit
        do_frame(0, 1'b0, 1'b0, "floor");
        check("floor.y_const", 32'(BallY), 32'd471);
        check("floor.game_over_const", 32'(game_over), 32'd1);

        // Dead: collide ignored, no motion
        do_frame(0, 1'b0, 1'b1, "dead_collide");
        do_frame(0, 1'b0, 1'b0, "dead_idle");
        check("dead.y_const", 32'(BallY), 32'd471);

        // Restart
        do_frame(1, 1'b0, 1'b0, "restart");
        check("restart.y_const", 32'(BallY), 32'd240);
        do_frame(1, 1'b0, 1'b0, "relaunch");

        // Climb to the ceiling with a flap every frame
        for (int i = 0; i < 50 && m_y != 12; i++) do_frame(1, 1'b0, 1'b0, "climb");
        check("climb.y_const", 32'(BallY), 32'd12);
        do_frame(1, 1'b0, 1'b0, "ceiling");
        check("ceiling.y_const", 32'(BallY), 32'd8);
        check("ceiling.state_const", 32'(st_o), 32'd1);
        do_frame(0, 1'b0, 1'b0, "after_ceiling");
        check("after_ceiling.y_const", 32'(BallY), 32'd9);

        for (int i = 0; i < 4; i++) do_frame(0, 1'b0, 1'b0, "drop");
        check("drop.y_const", 32'(BallY), 32'd23);

        // Flap edge coinciding with the tick, then no stale pending flap
        do_frame(0, 1'b1, 1'b0, "flap_on_tick");
        check("flap_on_tick.y_const", 32'(BallY), 32'd17);
        do_frame(0, 1'b0, 1'b0, "no_stale_flap");
        check("no_stale_flap.y_const", 32'(BallY), 32'd12);

        // Pipe collision freezes position
        do_frame(0, 1'b0, 1'b1, "collide");
        check("collide.y_const", 32'(BallY), 32'd12);
        check("collide.state_const", 32'(st_o), 32'd2);

        // Back to flying, then reset coinciding with a tick and a flap
        do_frame(1, 1'b0, 1'b0, "restart2");
        do_frame(1, 1'b0, 1'b0, "relaunch2");
        check("relaunch2.y_const", 32'(BallY), 32'd234);
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset    = 1'b1;
        flap_key = 1'b1;
        @(negedge Clk);
        Reset     = 1'b0;
        flap_key  = 1'b0;
        frame_clk = 1'b0;
        model_reset();
        check("midreset.state", 32'(st_o), 32'd0);
        check("midreset.y", 32'(BallY), 32'd240);
        check("midreset.alive", 32'(alive), 32'd0);
        repeat (4) @(negedge Clk);
        do_frame(0, 1'b0, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
